// File: rtl/mac_result_writer.sv
// Signed 8x8 multiply-accumulate over K terms per result, with a 2-entry result
// buffer that drains over valid/ready and flags (never stalls on) overruns.
module mac_result_writer #(
    parameter int M     = 64,
    parameter int K     = 64,
    parameter int N     = 64,
    parameter int ACC_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pe_in_valid,
    input  logic signed [7:0]       pe_a,
    input  logic signed [7:0]       pe_b,
    input  logic                    clear_acc,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [ACC_W-1:0] res_data,
    output logic [31:0]             res_addr,
    output logic                    busy,
    output logic                    done,
    output logic                    err_ovr,
    output logic                    err_seq,
    output logic                    err_sat
);
    localparam int KW = $clog2(K + 1);
    localparam logic [KW-1:0] K_FULL = KW'(K);
    localparam logic [KW-1:0] K_ONE  = KW'(1);
    localparam logic [31:0] LAST_ADDR = 32'(M * N - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Stage 1: registered product and first-of-group flag
    logic               s1_valid;
    logic signed [15:0] s1_prod;
    logic               s1_first;
    logic               started;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_first <= 1'b0;
            started  <= 1'b0;
        end else begin
            s1_valid <= pe_in_valid;
            if (pe_in_valid) begin
                s1_prod  <= pe_a * pe_b;
                s1_first <= clear_acc | ~started;
                started  <= 1'b1;
            end
        end
    end

    // Stage 2: accumulate with saturation and group sequencing
    logic signed [ACC_W-1:0] acc, acc_next, sum_sat;
    logic signed [ACC_W:0]   acc_ext, prod_ext, sum_wide;
    logic [KW-1:0]           k_cnt, k_next;
    logic                    sat_hit, sat_set, seq_hit, complete;

    always_comb begin
        acc_ext  = {acc[ACC_W-1], acc};
        prod_ext = {{(ACC_W-15){s1_prod[15]}}, s1_prod};
        sum_wide = acc_ext + prod_ext;
        sum_sat  = sum_wide[ACC_W-1:0];
        sat_hit  = 1'b0;
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            sat_hit = 1'b1;
            sum_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end

        acc_next = acc;
        k_next   = k_cnt;
        sat_set  = 1'b0;
        seq_hit  = 1'b0;
        complete = 1'b0;
        if (s1_valid) begin
            if (s1_first) begin
                seq_hit  = (k_cnt != '0) && (k_cnt != K_FULL);
                acc_next = prod_ext[ACC_W-1:0];
                k_next   = K_ONE;
                complete = (K_ONE == K_FULL);
            end else if (k_cnt == K_FULL) begin
                // Term beyond a finished group is dropped
                seq_hit = 1'b1;
            end else begin
                acc_next = sum_sat;
                sat_set  = sat_hit;
                k_next   = k_cnt + K_ONE;
                complete = ((k_cnt + K_ONE) == K_FULL);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            k_cnt   <= '0;
            err_seq <= 1'b0;
            err_sat <= 1'b0;
        end else begin
            acc   <= acc_next;
            k_cnt <= k_next;
            if (seq_hit) err_seq <= 1'b1;
            if (sat_set) err_sat <= 1'b1;
        end
    end

    // Result buffer: 2-entry FIFO, outputs driven from the head entry
    logic signed [ACC_W-1:0] buf_data [2];
    logic [31:0]             buf_addr [2];
    logic                    wr_ptr, rd_ptr;
    logic [1:0]              count;
    logic [31:0]             res_cnt;
    logic                    push, pop, accept;

    assign push      = complete;
    assign pop       = res_valid && res_ready;
    assign accept    = push && ((count != 2'd2) || pop);
    assign res_valid = (count != 2'd0);
    assign res_data  = buf_data[rd_ptr];
    assign res_addr  = buf_addr[rd_ptr];
    // A completed group holds no uncommitted data, only a partial one does
    assign busy      = s1_valid | ((k_cnt != '0) && (k_cnt != K_FULL)) | (count != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_addr[0] <= '0;
            buf_addr[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            res_cnt     <= '0;
            err_ovr     <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (accept) begin
                buf_data[wr_ptr] <= acc_next;
                buf_addr[wr_ptr] <= res_cnt;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            if (accept && !pop) begin
                count <= count + 2'd1;
            end else if (!accept && pop) begin
                count <= count - 2'd1;
            end
            // Dropped results still consume an address
            if (push) begin
                res_cnt <= (res_cnt == LAST_ADDR) ? '0 : res_cnt + 32'd1;
                if (!accept) err_ovr <= 1'b1;
            end
            if (pop && (res_addr == LAST_ADDR)) done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mac_result_writer.sv
// Bench for mac_result_writer: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a term-level behavioural model.
module tb_mac_result_writer;
    localparam int M = 2;
    localparam int N = 2;
    localparam int K = 4;
    localparam int W = 17;
    localparam longint ACC_MAX = (longint'(1) << (W - 1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) << (W - 1));

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               pe_in_valid = 1'b0;
    logic signed [7:0]  pe_a = '0;
    logic signed [7:0]  pe_b = '0;
    logic               clear_acc = 1'b0;
    logic               res_ready = 1'b0;
    logic               res_valid, busy, done, err_ovr, err_seq, err_sat;
    logic signed [W-1:0] res_data;
    logic [31:0]        res_addr;

    mac_result_writer #(.M(M), .K(K), .N(N), .ACC_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .pe_in_valid(pe_in_valid), .pe_a(pe_a), .pe_b(pe_b),
        .clear_acc(clear_acc), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_addr(res_addr), .busy(busy), .done(done),
        .err_ovr(err_ovr), .err_seq(err_seq), .err_sat(err_sat)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: whole-term arithmetic, results delayed one edge into a queue
    longint         m_acc;
    int             m_kc;
    bit             m_started;
    int             m_r;
    bit             m_ovr, m_seq, m_sat, m_done;
    bit             rec_v, rec_push, rec_seq, rec_sat;
    longint         rec_data;
    logic [W-1:0]   exp_q[$];
    logic [31:0]    exp_addr_q[$];
    longint         xfer_data_q[$];
    int             xfer_addr_q[$];

    task automatic model_term(input int p, input bit clr);
        bit first;
        longint s;
        first = clr || !m_started;
        m_started = 1'b1;
        if (first) begin
            if (m_kc > 0 && m_kc < K) rec_seq = 1'b1;
            m_acc = p;
            m_kc = 1;
        end else if (m_kc == K) begin
            rec_seq = 1'b1;
            return;
        end else begin
            s = m_acc + p;
            if (s > ACC_MAX) begin
                s = ACC_MAX;
                rec_sat = 1'b1;
            end else if (s < ACC_MIN) begin
                s = ACC_MIN;
                rec_sat = 1'b1;
            end
            m_acc = s;
            m_kc++;
        end
        if (m_kc == K) begin
            rec_push = 1'b1;
            rec_data = m_acc;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc = 0; m_kc = 0; m_started = 0; m_r = 0;
            m_ovr = 0; m_seq = 0; m_sat = 0; m_done = 0;
            rec_v = 0; rec_push = 0; rec_seq = 0; rec_sat = 0; rec_data = 0;
            exp_q.delete();
            exp_addr_q.delete();
        end else begin
            if (exp_q.size() != 0 && res_ready) begin
                if (exp_addr_q[0] == 32'(M * N - 1)) m_done = 1'b1;
                void'(exp_q.pop_front());
                void'(exp_addr_q.pop_front());
            end
            if (rec_seq) m_seq = 1'b1;
            if (rec_sat) m_sat = 1'b1;
            if (rec_push) begin
                if (exp_q.size() < 2) begin
                    exp_q.push_back(W'(rec_data));
                    exp_addr_q.push_back(32'(m_r));
                end else begin
                    m_ovr = 1'b1;
                end
                m_r = (m_r + 1) % (M * N);
            end
            rec_v = pe_in_valid;
            rec_push = 0; rec_seq = 0; rec_sat = 0;
            if (pe_in_valid) model_term(int'(pe_a) * int'(pe_b), clear_acc);
        end
    end

    // Scoreboard compare, every cycle away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                check("res_valid", res_valid, exp_q.size() != 0);
                if (res_valid && exp_q.size() != 0) begin
                    check("res_data", res_data, $signed(exp_q[0]));
                    check("res_addr", res_addr, exp_addr_q[0]);
                    if (res_ready) begin
                        xfer_data_q.push_back(longint'(res_data));
                        xfer_addr_q.push_back(int'(res_addr));
                    end
                end
                check("err_ovr", err_ovr, m_ovr);
                check("err_seq", err_seq, m_seq);
                check("err_sat", err_sat, m_sat);
                check("done", done, m_done);
                check("busy", busy, rec_v || (m_kc > 0 && m_kc < K) || exp_q.size() != 0);
            end
        end
    end

    // Driver tasks (entered and left on a falling edge)
    task automatic send(input int a, input int b, input bit clr);
        pe_in_valid = 1'b1;
        pe_a = 8'(a);
        pe_b = 8'(b);
        clear_acc = clr;
        @(negedge clk);
    endtask

    task automatic send_group(input int a, input int b);
        send(a, b, 1'b1);
        for (int i = 1; i < K; i++) send(a, b, 1'b0);
    endtask

    task automatic idle(input int n);
        pe_in_valid = 1'b0;
        clear_acc = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        pe_in_valid = 1'b0;
        clear_acc = 1'b0;
        res_ready = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        xfer_data_q.delete();
        xfer_addr_q.delete();
    endtask

    function automatic int rnd_op();
        if ($urandom_range(0, 7) == 0) return -128;
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    int gen_k;

    initial begin
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_addr", res_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {done, err_ovr, err_seq, err_sat}, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // T1: single result, latency and value
        send(1, 2, 1'b1); send(3, 4, 1'b0); send(-5, 6, 1'b0); send(7, -8, 1'b0);
        pe_in_valid = 1'b0;
        #1 check("t1_valid_t1", res_valid, 0);
        @(negedge clk);
        #1;
        check("t1_valid_t2", res_valid, 1);
        check("t1_data", res_data, -72);
        check("t1_addr", res_addr, 0);
        check("t1_model_data", $signed(exp_q[0]), -72);
        res_ready = 1'b1;
        idle(3);

        // T2: four results back to back, addresses in order, done
        do_reset;
        res_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            send(int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 200)) - 100, 1'b1);
            for (int i = 1; i < K; i++)
                send(int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 200)) - 100, 1'b0);
        end
        idle(6);
        check("t2_done", done, 1);
        check("t2_errs", {err_ovr, err_seq, err_sat}, 0);
        check("t2_xfer_cnt", xfer_addr_q.size(), 4);
        for (int i = 0; i < xfer_addr_q.size(); i++) check("t2_addr", xfer_addr_q[i], i);

        // T3: overrun drops the third result, address still advances
        do_reset;
        send_group(1, 1); send_group(2, 2); send_group(3, 3);
        idle(4);
        check("t3_valid", res_valid, 1);
        check("t3_head_addr", res_addr, 0);
        check("t3_head_data", res_data, 4);
        check("t3_ovr", err_ovr, 1);
        res_ready = 1'b1;
        idle(4);
        check("t3_xfer_cnt", xfer_addr_q.size(), 2);
        if (xfer_addr_q.size() == 2) begin
            check("t3_addr0", xfer_addr_q[0], 0);
            check("t3_addr1", xfer_addr_q[1], 1);
            check("t3_data1", xfer_data_q[1], 16);
        end
        xfer_addr_q.delete();
        xfer_data_q.delete();
        send_group(1, 1);
        idle(4);
        check("t3_next_cnt", xfer_addr_q.size(), 1);
        if (xfer_addr_q.size() == 1) check("t3_next_addr", xfer_addr_q[0], 3);

        // T4: short group restarts the sum
        do_reset;
        res_ready = 1'b1;
        send(1, 1, 1'b1); send(1, 1, 1'b0);
        send_group(2, 3);
        idle(4);
        check("t4_seq", err_seq, 1);
        check("t4_xfer_cnt", xfer_addr_q.size(), 1);
        if (xfer_addr_q.size() == 1) begin
            check("t4_data", xfer_data_q[0], 24);
            check("t4_addr", xfer_addr_q[0], 0);
        end

        // T5: saturation at ACC_W=17
        do_reset;
        res_ready = 1'b1;
        send_group(-128, -128);
        idle(4);
        check("t5_sat", err_sat, 1);
        check("t5_xfer_cnt", xfer_data_q.size(), 1);
        if (xfer_data_q.size() == 1) check("t5_data", xfer_data_q[0], 65535);

        // T6: reset mid-operation clears everything at once
        do_reset;
        send_group(1, 1);
        send(5, 5, 1'b0);
        send(2, 2, 1'b1); send(2, 2, 1'b0);
        pe_in_valid = 1'b0;
        check("t6_pre_busy", busy, 1);
        check("t6_pre_valid", res_valid, 1);
        check("t6_pre_seq", err_seq, 1);
        rst_n = 1'b0;
        #1;
        check("t6_valid", res_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_flags", {done, err_ovr, err_seq, err_sat}, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        xfer_addr_q.delete();
        xfer_data_q.delete();
        res_ready = 1'b1;
        send_group(3, 1);
        idle(4);
        check("t6_xfer_cnt", xfer_addr_q.size(), 1);
        if (xfer_addr_q.size() == 1) check("t6_addr", xfer_addr_q[0], 0);

        // Randomized traffic against the model
        do_reset;
        gen_k = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                do_reset;
                gen_k = 0;
            end
            res_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) begin
                pe_in_valid = 1'b1;
                pe_a = 8'(rnd_op());
                pe_b = 8'(rnd_op());
                clear_acc = (gen_k == 0) ? 1'b1 : ($urandom_range(0, 40) == 0);
                if (clear_acc) gen_k = 1;
                else gen_k++;
                if (gen_k >= K && $urandom_range(0, 9) != 0) gen_k = 0;
            end else begin
                pe_in_valid = 1'b0;
                clear_acc = 1'b0;
            end
            @(negedge clk);
        end
        res_ready = 1'b1;
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
